inst_rom_loader: RTL



---
 rtl/inst_rom_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - boot-loaded instruction ROM answering the core's zero-latency fetch port
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              load_valid_i,
  input  logic [7:0]        load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              cpu_rst_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   load_words_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] WPTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [1:0]        byte_cnt, byte_cnt_d;
  logic [ADDR_W:0]   wptr, wptr_d;
  logic [31:0]       word_buf, word_buf_d;
  logic [31:0]       word_asm;
  logic              mem_we;
  logic              mem_full;

  logic [31:0]       mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      wptr     <= '0;
      word_buf <= '0;
    end else begin
      state    <= state_d;
      byte_cnt <= byte_cnt_d;
      wptr     <= wptr_d;
      word_buf <= word_buf_d;
    end
  end

  // Memory is intentionally left out of reset; only wptr defines which words are valid.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr[ADDR_W-1:0]] <= word_asm;
    end
  end

  assign mem_full = (wptr == DEPTH_W);

  // Big-endian packing; bytes not yet received stay zero because word_buf clears after each write.
  always_comb begin
    word_asm = word_buf;
    case (byte_cnt)
      2'd0:    word_asm = {load_data_i, 24'h0};
      2'd1:    word_asm = {word_buf[31:24], load_data_i, 16'h0};
      2'd2:    word_asm = {word_buf[31:16], load_data_i, 8'h0};
      default: word_asm = {word_buf[31:8], load_data_i};
    endcase
  end

  always_comb begin
    state_d    = state;
    byte_cnt_d = byte_cnt;
    wptr_d     = wptr;
    word_buf_d = word_buf;
    mem_we     = 1'b0;
    case (state)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (load_valid_i) begin
          // A byte arriving with no room left is an overflow even if it carries last.
          if (mem_full) begin
            state_d = ERR;
          end else begin
            if (byte_cnt == 2'd3 || load_last_i) begin
              mem_we     = 1'b1;
              wptr_d     = wptr + WPTR_ONE;
              byte_cnt_d = 2'd0;
              word_buf_d = '0;
            end else begin
              word_buf_d = word_asm;
              byte_cnt_d = byte_cnt + 2'd1;
            end
            if (load_last_i) begin
              state_d = RUN;
            end
          end
        end
      end
      default: state_d = state;
    endcase
  end

  assign load_ready_o = (state == LOAD);
  assign cpu_rst_o    = (state != RUN);
  assign load_done_o  = (state == RUN);
  assign load_err_o   = (state == ERR);
  assign load_words_o = wptr;

  logic [ADDR_W-1:0] rd_idx;
  logic              rd_in_range;
  logic              rd_hit;

  assign rd_idx      = rom_addr_i[ADDR_W+1:2];
  assign rd_in_range = (rom_addr_i[31:ADDR_W+2] == '0);
  assign rd_hit      = (state == RUN) && rom_ce_i && rd_in_range && ({1'b0, rd_idx} < wptr);
  assign rom_data_o  = rd_hit ? mem[rd_idx] : 32'h0;

endmodule
